// File: rtl/signed_seq_divider_if.sv
// Operand/result bundle for the sequential signed divider.
interface signed_seq_divider_if #(parameter int N = 8);
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [N-1:0]     quotient;
  logic [N-1:0]     remainder;
  logic             ovf;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, ovf, dbz
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Restoring signed divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Quotient truncates toward zero and saturates on overflow; remainder takes the dividend's sign.
module signed_seq_divider #(
  parameter int N = 8
) (
  input logic                 clk,
  input logic                 rst,
  signed_seq_divider_if.slave bus
);
  localparam int CW = $clog2(2*N+1);
  localparam logic [2*N-1:0] QPOS = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] QNEG = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]   MAXV = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]   MINV = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t          state;
  logic [N-1:0]    pr;
  logic [2*N-1:0]  dq;
  logic [N-1:0]    dvs;
  logic [CW-1:0]   cnt;
  logic            sign_q;
  logic            sign_r;
  logic            zdiv;

  logic [2*N-1:0]  a_mag;
  logic [N-1:0]    b_mag;
  logic [N:0]      shifted;
  logic [N-1:0]    diffv;
  logic            ge;
  logic            q_ovf;
  logic [N-1:0]    q_fix;
  logic [N-1:0]    r_fix;

  // pr stays below |divisor| <= 2^(N-1), so N bits hold it and the shifted
  // value needs only one extra bit; the subtraction result always fits N bits.
  always_comb begin
    a_mag   = bus.dividend[2*N-1] ? -bus.dividend : bus.dividend;
    b_mag   = bus.divisor[N-1] ? -bus.divisor : bus.divisor;
    shifted = {pr, dq[2*N-1]};
    ge      = shifted >= {1'b0, dvs};
    diffv   = shifted[N-1:0] - dvs;
    q_ovf   = sign_q ? (dq > QNEG) : (dq > QPOS);
    q_fix   = q_ovf ? (sign_q ? MINV : MAXV)
                    : (sign_q ? -dq[N-1:0] : dq[N-1:0]);
    r_fix   = sign_r ? -pr : pr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.ovf       <= 1'b0;
      bus.dbz       <= 1'b0;
      pr            <= '0;
      dq            <= '0;
      dvs           <= '0;
      cnt           <= '0;
      sign_q        <= 1'b0;
      sign_r        <= 1'b0;
      zdiv          <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            dq       <= a_mag;
            dvs      <= b_mag;
            pr       <= '0;
            sign_q   <= bus.dividend[2*N-1] ^ bus.divisor[N-1];
            sign_r   <= bus.dividend[2*N-1];
            zdiv     <= (bus.divisor == '0);
            // A zero divisor spends a single DIV slot so its result lands two edges after start.
            cnt      <= (bus.divisor == '0) ? CW'(1) : CW'(2*N);
            state    <= DIV;
            bus.busy <= 1'b1;
          end
        end
        DIV: begin
          pr  <= ge ? diffv : shifted[N-1:0];
          dq  <= {dq[2*N-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (zdiv) begin
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.dbz       <= 1'b1;
          end else begin
            bus.quotient  <= q_fix;
            bus.remainder <= r_fix;
            bus.ovf       <= q_ovf;
            bus.dbz       <= 1'b0;
          end
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_seq_divider.sv
// Bench for signed_seq_divider: directed vector table, handshake/reset sequences,
// and randomized operands checked against the language's signed / and %.
module tb_signed_seq_divider;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  signed_seq_divider_if #(.N(8)) bus ();

  signed_seq_divider #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic signed [7:0] q;
    logic signed [7:0] r;
    logic              ovf;
    logic              dbz;
    int                lat;
    int                acc;
    string             tag;
  } exp_t;

  typedef struct {
    logic signed [15:0] a;
    logic signed [7:0]  b;
    logic signed [7:0]  q;
    logic signed [7:0]  r;
    logic               ovf;
    logic               dbz;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t model(input logic signed [15:0] a, input logic signed [7:0] b);
    exp_t e;
    int   qi;
    int   ri;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.lat = 17;
    e.acc = 0;
    e.tag = "rand";
    if (b == 8'sd0) begin
      e.q   = '0;
      e.r   = '0;
      e.dbz = 1'b1;
      e.lat = 2;
    end else begin
      qi  = int'(a) / int'(b);
      ri  = int'(a) % int'(b);
      e.r = 8'(ri);
      if (qi > 127) begin
        e.ovf = 1'b1;
        e.q   = 8'h7f;
      end else if (qi < -128) begin
        e.ovf = 1'b1;
        e.q   = 8'h80;
      end else begin
        e.q = 8'(qi);
      end
    end
    return e;
  endfunction

  // Result monitor: pops the scoreboard on every done pulse.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.tag, ".quotient"},  int'($signed(bus.quotient)),  int'(e.q));
        chk({e.tag, ".remainder"}, int'($signed(bus.remainder)), int'(e.r));
        chk({e.tag, ".ovf"},       int'(bus.ovf),  int'(e.ovf));
        chk({e.tag, ".dbz"},       int'(bus.dbz),  int'(e.dbz));
        chk({e.tag, ".latency"},   cyc - e.acc,    e.lat);
        chk({e.tag, ".busy_at_done"}, int'(bus.busy), 0);
      end
    end
  end

  // Called at a negedge; drives start for one cycle, then scrambles the operands.
  task automatic issue(input logic signed [15:0] a, input logic signed [7:0] b,
                       input exp_t e, input string tag);
    exp_t x;
    x = e;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (!bus.busy && !rst) begin
      x.acc = cyc + 1;
      x.tag = tag;
      sb.push_back(x);
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout: got %0d results pending expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    exp_t e;
    logic signed [15:0] a;
    logic signed [7:0]  b;
    int ndone;

    cyc       = 0;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    vecs.push_back('{a:  16'sd300,   b: -8'sd7,   q: -8'sd42,  r:  8'sd6,   ovf: 1'b0, dbz: 1'b0});
    vecs.push_back('{a: -16'sd1000,  b:  8'sd13,  q: -8'sd76,  r: -8'sd12,  ovf: 1'b0, dbz: 1'b0});
    vecs.push_back('{a:  16'sd16384, b:  8'h80,   q:  8'h80,   r:  8'sd0,   ovf: 1'b0, dbz: 1'b0});
    vecs.push_back('{a:  16'sd16384, b:  8'sd1,   q:  8'sd127, r:  8'sd0,   ovf: 1'b1, dbz: 1'b0});
    vecs.push_back('{a:  16'h8000,   b: -8'sd1,   q:  8'sd127, r:  8'sd0,   ovf: 1'b1, dbz: 1'b0});
    vecs.push_back('{a:  16'sd500,   b:  8'sd0,   q:  8'sd0,   r:  8'sd0,   ovf: 1'b0, dbz: 1'b1});
    vecs.push_back('{a: -16'sd77,    b:  8'sd9,   q: -8'sd8,   r: -8'sd5,   ovf: 1'b0, dbz: 1'b0});
    vecs.push_back('{a:  16'h8000,   b:  8'sd7,   q:  8'h80,   r: -8'sd1,   ovf: 1'b1, dbz: 1'b0});
    vecs.push_back('{a:  16'sd0,     b: -8'sd5,   q:  8'sd0,   r:  8'sd0,   ovf: 1'b0, dbz: 1'b0});
    vecs.push_back('{a:  16'h8000,   b:  8'h80,   q:  8'sd127, r:  8'sd0,   ovf: 1'b1, dbz: 1'b0});
    vecs.push_back('{a:  16'sd32767, b:  8'h80,   q:  8'h80,   r:  8'sd127, ovf: 1'b1, dbz: 1'b0});
    vecs.push_back('{a:  16'sd16383, b:  8'h80,   q: -8'sd127, r:  8'sd127, ovf: 1'b0, dbz: 1'b0});

    repeat (3) @(negedge clk);
    chk("reset.busy",      int'(bus.busy), 0);
    chk("reset.done",      int'(bus.done), 0);
    chk("reset.quotient",  int'(bus.quotient), 0);
    chk("reset.remainder", int'(bus.remainder), 0);
    chk("reset.ovf",       int'(bus.ovf), 0);
    chk("reset.dbz",       int'(bus.dbz), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      e.q   = vecs[i].q;
      e.r   = vecs[i].r;
      e.ovf = vecs[i].ovf;
      e.dbz = vecs[i].dbz;
      e.lat = vecs[i].dbz ? 2 : 17;
      e.acc = 0;
      issue(vecs[i].a, vecs[i].b, e, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Start while busy is ignored; start in the done cycle is accepted back to back.
    issue(16'sd300, -8'sd7, model(16'sd300, -8'sd7), "b2b_first");
    repeat (4) @(negedge clk);
    issue(16'sd1234, 8'sd3, model(16'sd1234, 8'sd3), "ignored");
    repeat (12) @(negedge clk);
    chk("b2b.done_cycle", int'(bus.done), 1);
    issue(-16'sd1000, 8'sd13, model(-16'sd1000, 8'sd13), "b2b_second");
    wait_idle("b2b");
    @(negedge clk);

    // Reset at DIV iteration 8 aborts without a done pulse.
    issue(16'sd300, -8'sd7, model(16'sd300, -8'sd7), "aborted");
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort.busy",      int'(bus.busy), 0);
    chk("abort.done",      int'(bus.done), 0);
    chk("abort.quotient",  int'(bus.quotient), 0);
    chk("abort.remainder", int'(bus.remainder), 0);
    chk("abort.ovf",       int'(bus.ovf), 0);
    chk("abort.dbz",       int'(bus.dbz), 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("abort.no_done", ndone, 0);
    issue(-16'sd77, 8'sd9, model(-16'sd77, 8'sd9), "after_abort");
    wait_idle("after_abort");
    @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 16'($urandom);
        1:       a = 16'($urandom_range(0, 4095)) - 16'd2048;
        2:       a = 16'h8000;
        default: a = 16'($urandom_range(0, 32767)) - 16'd16384;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 8'sd0;
        1:       b = 8'h80;
        2:       b = ($urandom_range(0, 1) == 0) ? 8'sd1 : -8'sd1;
        default: b = 8'($urandom);
      endcase
      issue(a, b, model(a, b), $sformatf("rand%0d", i));
      wait_idle("rand");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/signed_seq_divider.md
Name: signed_seq_divider

Overview:
- Sequential signed fixed-point divider; the inverse of the team's 8x8 signed Dadda multiplier.
- Takes a 2N-bit signed dividend (the product width) and an N-bit signed divisor.
- Returns an N-bit signed quotient and remainder, with overflow and divide-by-zero flags.
- Uses one restoring shift-subtract iteration per clock. It sits next to the multiplier so the datapath can recover an operand from a product.

Parameters:
N, 8, divisor/quotient/remainder width; dividend width is 2N

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  2N  signed dividend, captured on accepted start
divisor  input  N  signed divisor, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: results valid
quotient  output  N  signed quotient, truncated toward zero
remainder  output  N  signed remainder, sign of dividend
ovf  output  1  quotient not representable in N signed bits
dbz  output  1  divisor was zero

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE; busy, done, ovf, dbz, quotient and remainder all 0.
  - Reset has priority over everything. Reset mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE. start=1 captures the operands.
    - divisor==0: go to FIX with the dbz path selected.
    - Otherwise: store |dividend| (2N bits unsigned) and |divisor| (N bits unsigned; -2^(N-1) gives 2^(N-1)), save sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), clear the partial remainder, load iteration count 2N, go to DIV.
  - DIV, one iteration per edge:
    - Shift {partial remainder (N+1 bits), dividend magnitude} left by 1.
    - If partial remainder >= |divisor|, subtract it and set the quotient bit to 1.
    - After 2N iterations go to FIX.
  - FIX, one edge:
    - Apply the signs: quotient = sign_q ? -Qmag : Qmag; remainder = sign_r ? -Rmag : Rmag.
    - Register quotient, remainder, ovf and dbz; assert done for exactly one cycle; go to IDLE.
- Overflow:
  - The signed 2N-bit quotient falls outside [-2^(N-1), 2^(N-1)-1].
  - Then ovf=1 and quotient saturates to 2^(N-1)-1 when sign_q=0, or -2^(N-1) when sign_q=1.
  - remainder still holds the exact truncating remainder (|r| < |divisor| always fits N bits).
- Divide-by-zero: dbz=1, quotient=0, remainder=0, ovf=0.
- Results satisfy dividend == quotient*divisor + remainder when ovf=0 and dbz=0. This matches SystemVerilog signed / and %.
- Latency:
  - Counted from the edge that samples start.
  - Normal case: done is high after edge 2N+1 (17 clocks for N=8).
  - dbz case: done is high after edge 2.
- busy is 1 in DIV and FIX, and 0 in IDLE, including the cycle where done=1.
- Handshake:
  - start while busy=1 is ignored; the operands are not recaptured.
  - start during the done cycle is accepted, which gives back-to-back operation with no bubble.
  - Operands only need to be valid on the accepting edge.
- Output hold: quotient, remainder, ovf and dbz hold their values from the done cycle until the next FIX. A new start does not clear them; done is the only valid qualifier.
- Boundary cases:
  - Most-negative dividend (-2^(2N-1)) must take the magnitude path correctly, using an unsigned 2N-bit magnitude.
  - A zero dividend gives q=0, r=0.

Test Plan:
1. N=8, dividend=300, divisor=-7 -> done 17 clocks after start; quotient=-42, remainder=6, ovf=0, dbz=0.
2. dividend=-1000, divisor=13 -> quotient=-76, remainder=-12. Then dividend=16384, divisor=-128 -> quotient=-128, remainder=0, ovf=0.
3. dividend=16384, divisor=1 -> ovf=1, quotient=127, remainder=0. Then dividend=-32768, divisor=-1 -> ovf=1, quotient=127, remainder=0.
4. dividend=500, divisor=0 -> done 2 clocks after start; dbz=1, quotient=0, remainder=0, ovf=0.
5. Issue start during the busy phase (cycle 5) with different operands -> ignored, first result unchanged. Assert start in the done cycle -> second op accepted; its done arrives 17 clocks later.
6. Assert rst at DIV iteration 8 -> next cycle busy=0, all outputs 0, no done pulse. A subsequent op (-77/9 -> q=-8, r=-5) completes correctly.
7. Random: at least 1000 random signed operand pairs checked against the SystemVerilog / and % reference, with the saturation and dbz rules applied.
